bomba_ctrl: RTL and testbench

Game controller that sequences the 3-minute countdown timer of the bomb puzzle. It holds the timer in reset until the player starts, then enables it. It collects a keypad code and checks it against a secret. It counts wrong attempts, applies a lockout after each wrong code, and ends in a DEFUSED or EXPLODED terminal state.

---
 rtl/bomba_pkg.sv | 31 +++
 rtl/bomba_beeper.sv | 45 ++++
 rtl/bomba_ctrl.sv | 168 ++++++++++++++++
 tb/tb_bomba_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomba_pkg.sv
// Shared definitions for the bomb puzzle game controller.
//   - state_e      : FSM state codes (also exported on the display mux port)
//   - DigitW       : width of one BCD keypad digit
//   - ClkHz        : system clock frequency; timing defaults derive from it
//   - code_mask()  : nibble mask selecting the low code_len digits of a code
package bomba_pkg;

  localparam int unsigned DigitW        = 4;
  localparam int unsigned ClkHz         = 50_000_000;
  localparam int unsigned LockCyclesDef = ClkHz / 5;   // 0.2 s keypad lockout
  localparam int unsigned BeepCyclesDef = ClkHz / 20;  // 50 ms beep per digit

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRunning  = 3'd1,
    StCheck    = 3'd2,
    StLocked   = 3'd3,
    StDefused  = 3'd4,
    StExploded = 3'd5
  } state_e;

  function automatic logic [31:0] code_mask(input int unsigned code_len);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < code_len) mask[i*DigitW +: DigitW] = '1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bomba_beeper.sv
// Retriggerable one-shot driving the buzzer.
//   clk, reset : system clock, asynchronous active-high reset
//   trigger    : (re)starts a pulse of BEEP_CYCLES cycles
//   force_on   : holds buzzer high (takes priority over force_off)
//   force_off  : holds buzzer low; the pulse counter keeps running underneath
//   buzzer     : registered buzzer drive
module bomba_beeper
  import bomba_pkg::*;
#(
  parameter int unsigned BEEP_CYCLES = BeepCyclesDef
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic force_on,
  input  logic force_off,
  output logic buzzer
);

  localparam int unsigned CntW = $clog2(BEEP_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            buzzer_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger) begin
      cnt_d = CntW'(BEEP_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
    buzzer_d = force_on | (!force_off && (cnt_d != '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      buzzer <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      buzzer <= buzzer_d;
    end
  end

endmodule

// File: rtl/bomba_ctrl.sv
// Bomb puzzle game controller: sequences the countdown timer, collects and checks
// the keypad code, counts wrong attempts with a lockout after each, and ends in
// DEFUSED or EXPLODED.
//   clk, reset      : 50 MHz clock, asynchronous active-high reset
//   start_btn       : start a game (IDLE) / begin a new game (terminal states)
//   clear_btn       : discard the partially entered code
//   digit_valid     : keypad strobe qualifying digit
//   digit           : BCD digit from keypad
//   tmr_expired     : countdown timer reached zero
//   tmr_reset       : timer reset drive (high only in IDLE)
//   tmr_enable      : timer enable (high in RUNNING, CHECK, LOCKED)
//   state           : current FSM state code
//   errors_left     : wrong codes still allowed
//   digits_entered  : digits currently buffered
//   buzzer          : beep pulse / continuous tone when exploded
//   defused         : high in DEFUSED
//   exploded        : high in EXPLODED
// LOCK_CYCLES must be at least 1.
module bomba_ctrl
  import bomba_pkg::*;
#(
  parameter int unsigned CODE_LEN    = 4,
  parameter logic [31:0] SECRET      = 32'h0000_1234,
  parameter int unsigned MAX_ERRORS  = 3,
  parameter int unsigned LOCK_CYCLES = LockCyclesDef,
  parameter int unsigned BEEP_CYCLES = BeepCyclesDef
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
  input  logic              clear_btn,
  input  logic              digit_valid,
  input  logic [DigitW-1:0] digit,
  input  logic              tmr_expired,
  output logic              tmr_reset,
  output logic              tmr_enable,
  output logic [2:0]        state,
  output logic [1:0]        errors_left,
  output logic [3:0]        digits_entered,
  output logic              buzzer,
  output logic              defused,
  output logic              exploded
);

  localparam int unsigned      LockW      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [31:0]      Mask       = code_mask(CODE_LEN);
  localparam logic [1:0]       ErrInit    = 2'(MAX_ERRORS);
  localparam logic [3:0]       DigitsFull = 4'(CODE_LEN);
  localparam logic [LockW-1:0] LockLoad   = LockW'(LOCK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      code_q, code_d;
  logic [3:0]       digits_q, digits_d;
  logic [1:0]       err_q, err_d;
  logic [LockW-1:0] lock_q, lock_d;
  logic             beep_trig;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    digits_d  = digits_q;
    err_d     = err_q;
    lock_d    = lock_q;
    beep_trig = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_btn) state_d = StRunning;
      end

      StRunning: begin
        if (tmr_expired) begin
          state_d = StExploded;
        end else if (clear_btn) begin
          // Clear beats a same-cycle digit.
          code_d   = '0;
          digits_d = '0;
        end else if (digit_valid && (digit <= 4'd9)) begin
          code_d    = {code_q[31-DigitW:0], digit};
          digits_d  = digits_q + 4'd1;
          beep_trig = 1'b1;
          if (digits_d == DigitsFull) state_d = StCheck;
        end
      end

      StCheck: begin
        code_d   = '0;
        digits_d = '0;
        if (tmr_expired) begin
          state_d = StExploded;
        end else if ((code_q & Mask) == (SECRET & Mask)) begin
          state_d = StDefused;
        end else begin
          err_d = err_q - 2'd1;
          if (err_d == 2'd0) begin
            state_d = StExploded;
          end else begin
            state_d = StLocked;
            lock_d  = LockLoad;
          end
        end
      end

      StLocked: begin
        if (tmr_expired) begin
          state_d = StExploded;
        end else if (lock_q == '0) begin
          state_d = StRunning;
        end else begin
          lock_d = lock_q - LockW'(1);
        end
      end

      StDefused, StExploded: begin
        if (start_btn) begin
          state_d  = StIdle;
          err_d    = ErrInit;
          code_d   = '0;
          digits_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Timer/flag outputs are registered from the next state so they change in
  // the same cycle the new state becomes visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      code_q     <= '0;
      digits_q   <= '0;
      err_q      <= ErrInit;
      lock_q     <= '0;
      tmr_reset  <= 1'b1;
      tmr_enable <= 1'b0;
      defused    <= 1'b0;
      exploded   <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      digits_q   <= digits_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
      tmr_reset  <= (state_d == StIdle);
      tmr_enable <= (state_d == StRunning) || (state_d == StCheck) || (state_d == StLocked);
      defused    <= (state_d == StDefused);
      exploded   <= (state_d == StExploded);
    end
  end

  assign state          = state_q;
  assign errors_left    = err_q;
  assign digits_entered = digits_q;

  bomba_beeper #(
    .BEEP_CYCLES (BEEP_CYCLES)
  ) u_beeper (
    .clk       (clk),
    .reset     (reset),
    .trigger   (beep_trig),
    .force_on  (state_d == StExploded),
    .force_off ((state_d == StIdle) || (state_d == StDefused)),
    .buzzer    (buzzer)
  );

endmodule

// File: tb/tb_bomba_ctrl.sv
// Self-checking bench for bomba_ctrl: directed scenarios followed by random
// keypad/button traffic, all compared every cycle against a behavioural model
// that tracks the game with a digit queue and plain integer counters.
module tb_bomba_ctrl;

  localparam int unsigned CODE_LEN    = 4;
  localparam logic [31:0] SECRET      = 32'h0000_1234;
  localparam int unsigned MAX_ERRORS  = 3;
  localparam int unsigned LOCK_CYCLES = 8;
  localparam int unsigned BEEP_CYCLES = 4;

  localparam int M_IDLE = 0, M_RUN = 1, M_CHECK = 2, M_LOCK = 3, M_DEF = 4, M_EXP = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0, clear_btn = 1'b0, digit_valid = 1'b0, tmr_expired = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       tmr_reset, tmr_enable, buzzer, defused, exploded;
  logic [2:0] state;
  logic [1:0] errors_left;
  logic [3:0] digits_entered;

  bomba_ctrl #(
    .CODE_LEN    (CODE_LEN),
    .SECRET      (SECRET),
    .MAX_ERRORS  (MAX_ERRORS),
    .LOCK_CYCLES (LOCK_CYCLES),
    .BEEP_CYCLES (BEEP_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_btn      (start_btn),
    .clear_btn      (clear_btn),
    .digit_valid    (digit_valid),
    .digit          (digit),
    .tmr_expired    (tmr_expired),
    .tmr_reset      (tmr_reset),
    .tmr_enable     (tmr_enable),
    .state          (state),
    .errors_left    (errors_left),
    .digits_entered (digits_entered),
    .buzzer         (buzzer),
    .defused        (defused),
    .exploded       (exploded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model
  int m_state, m_err, m_lock, m_beep;
  int m_code[$];

  function automatic void model_reset();
    m_state = M_IDLE;
    m_err   = MAX_ERRORS;
    m_lock  = 0;
    m_beep  = 0;
    m_code.delete();
  endfunction

  function automatic bit code_matches();
    longint v = 0;
    longint want = longint'(SECRET) & ((64'd1 << (4 * CODE_LEN)) - 1);
    foreach (m_code[i]) v = v * 16 + m_code[i];
    return v == want;
  endfunction

  function automatic void model_step(bit st, bit cl, bit dv, int d, bit ex);
    if (m_beep > 0) m_beep--;
    case (m_state)
      M_IDLE: if (st) m_state = M_RUN;
      M_RUN: begin
        if (ex) m_state = M_EXP;
        else if (cl) m_code.delete();
        else if (dv && d <= 9) begin
          m_code.push_back(d);
          m_beep = BEEP_CYCLES;
          if (m_code.size() == CODE_LEN) m_state = M_CHECK;
        end
      end
      M_CHECK: begin
        if (ex) m_state = M_EXP;
        else if (code_matches()) m_state = M_DEF;
        else begin
          m_err--;
          if (m_err == 0) m_state = M_EXP;
          else begin
            m_state = M_LOCK;
            m_lock  = LOCK_CYCLES;
          end
        end
        m_code.delete();
      end
      M_LOCK: begin
        if (ex) m_state = M_EXP;
        else begin
          m_lock--;
          if (m_lock == 0) m_state = M_RUN;
        end
      end
      default: begin
        if (st) begin
          m_state = M_IDLE;
          m_err   = MAX_ERRORS;
          m_code.delete();
        end
      end
    endcase
  endfunction

  function automatic int exp_buzzer();
    if (m_state == M_EXP) return 1;
    if (m_state == M_IDLE || m_state == M_DEF) return 0;
    return (m_beep > 0) ? 1 : 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("state", 32'(state), m_state);
    check_eq("errors_left", 32'(errors_left), m_err);
    check_eq("digits_entered", 32'(digits_entered), m_code.size());
    check_eq("buzzer", 32'(buzzer), exp_buzzer());
    check_eq("tmr_reset", 32'(tmr_reset), (m_state == M_IDLE) ? 1 : 0);
    check_eq("tmr_enable", 32'(tmr_enable),
             (m_state == M_RUN || m_state == M_CHECK || m_state == M_LOCK) ? 1 : 0);
    check_eq("defused", 32'(defused), (m_state == M_DEF) ? 1 : 0);
    check_eq("exploded", 32'(exploded), (m_state == M_EXP) ? 1 : 0);
  endtask

  task automatic tick(input bit st, input bit cl, input bit dv, input logic [3:0] d,
                      input bit ex);
    start_btn   = st;
    clear_btn   = cl;
    digit_valid = dv;
    digit       = d;
    tmr_expired = ex;
    @(posedge clk);
    model_step(st, cl, dv, int'(d), ex);
    #1;
    start_btn   = 1'b0;
    clear_btn   = 1'b0;
    digit_valid = 1'b0;
    tmr_expired = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic enter(input logic [3:0] d);
    tick(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic enter_code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] e);
    enter(a);
    enter(b);
    enter(c);
    enter(e);
  endtask

  initial begin
    bit st, cl, dv, ex;
    logic [3:0] d;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // 1: start
    tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("t1_state_running", 32'(state), 1);
    check_eq("t1_tmr_reset_low", 32'(tmr_reset), 0);
    check_eq("t1_errors", 32'(errors_left), 3);

    // 2: correct code
    enter(4'd1);
    check_eq("t2_beep_on", 32'(buzzer), 1);
    enter(4'd2);
    enter(4'd3);
    enter(4'd4);
    check_eq("t2_check_state", 32'(state), 2);
    idle(1);
    check_eq("t2_defused", 32'(defused), 1);
    check_eq("t2_tmr_frozen", 32'(tmr_enable), 0);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

    // 3: wrong code, lockout ignores keypad
    enter_code(4'd9, 4'd9, 4'd9, 4'd9);
    idle(1);
    check_eq("t3_locked", 32'(state), 3);
    check_eq("t3_errors", 32'(errors_left), 2);
    for (int i = 0; i < LOCK_CYCLES; i++) enter(4'd5);
    check_eq("t3_lock_digits", 32'(digits_entered), 0);
    check_eq("t3_back_running", 32'(state), 1);

    // 4: exhaust attempts
    enter_code(4'd8, 4'd8, 4'd8, 4'd8);
    idle(1);
    check_eq("t4_errors1", 32'(errors_left), 1);
    idle(LOCK_CYCLES);
    enter_code(4'd0, 4'd0, 4'd0, 4'd0);
    idle(1);
    check_eq("t4_exploded", 32'(exploded), 1);
    check_eq("t4_errors0", 32'(errors_left), 0);
    idle(6);
    check_eq("t4_tone", 32'(buzzer), 1);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("t4_idle_errors", 32'(errors_left), 3);

    // 5: clear beats digit; non-BCD ignored
    tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    enter(4'd1);
    enter(4'd2);
    enter(4'd3);
    tick(1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
    check_eq("t5_cleared", 32'(digits_entered), 0);
    idle(4);
    enter(4'hA);
    check_eq("t5_nonbcd_digits", 32'(digits_entered), 0);
    check_eq("t5_nonbcd_beep", 32'(buzzer), 0);

    // 6: expiry during CHECK overrides a correct code; async reset in LOCKED
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    check_eq("t6_exploded", 32'(state), 5);
    check_eq("t6_not_defused", 32'(defused), 0);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    enter_code(4'd5, 4'd5, 4'd5, 4'd5);
    idle(3);
    #3 reset = 1'b1;
    #1;
    check_eq("t6_rst_state", 32'(state), 0);
    check_eq("t6_rst_tmr_reset", 32'(tmr_reset), 1);
    check_eq("t6_rst_tmr_enable", 32'(tmr_enable), 0);
    check_eq("t6_rst_errors", 32'(errors_left), 3);
    model_reset();
    #1 reset = 1'b0;
    compare_all();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_state == M_IDLE) st = ($urandom_range(0, 3) == 0);
      else if (m_state == M_DEF || m_state == M_EXP) st = ($urandom_range(0, 7) == 0);
      else st = ($urandom_range(0, 31) == 0);
      cl = ($urandom_range(0, 15) == 0);
      dv = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1 && m_code.size() < CODE_LEN)
        d = 4'((SECRET >> (4 * (CODE_LEN - 1 - m_code.size()))) & 32'hF);
      else
        d = 4'($urandom_range(0, 15));
      ex = ($urandom_range(0, 99) == 0);
      tick(st, cl, dv, d, ex);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
